// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the misao memory responder: boot FSM states,
// I/O window register offsets and status register bit positions.
package misao_mem_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] IO_GPIO   = 2'd0;
  localparam logic [1:0] IO_TMR_LO = 2'd1;
  localparam logic [1:0] IO_TMR_HI = 2'd2;
  localparam logic [1:0] IO_STATUS = 2'd3;

  localparam int STATUS_ERR = 0;
  localparam int STATUS_OVF = 1;

endpackage

// File: rtl/misao_mem_responder_if.sv
// Core bus, boot-load stream and status outputs of the misao memory responder.
// Boot stream: a byte transfers on a rising clk edge when ld_valid && ld_ready;
// ld_data/ld_last are held stable while ld_valid waits for ld_ready.
interface misao_mem_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              mem_enable_read;
  logic              mem_enable_write;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              core_rst;
  logic [DATA_W-1:0] gpio_out;
  logic              err_access;

  modport master (
    output mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    output ld_valid, ld_data, ld_last,
    input  mem_data_in, ld_ready, core_rst, gpio_out, err_access
  );

  modport slave (
    input  mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    input  ld_valid, ld_data, ld_last,
    output mem_data_in, ld_ready, core_rst, gpio_out, err_access
  );
endinterface

// File: rtl/misao_io_regs.sv
// GPIO, status and (when MISAO_MEM_TIMER_EN is defined) timer/shadow registers
// of the responder's I/O window, with their read mux.
module misao_io_regs
  import misao_mem_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              rd,
  input  logic              wr,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_set,
  input  logic              ovf_set,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] gpio,
  output logic              err
);

  logic              ovf;
  logic              clr_err;
  logic              clr_ovf;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] tmr_lo;
  logic [DATA_W-1:0] tmr_hi;

  assign clr_err = wr && (offset == IO_STATUS) && wdata[STATUS_ERR];
  assign clr_ovf = wr && (offset == IO_STATUS) && wdata[STATUS_OVF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio <= '0;
      err  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (wr && (offset == IO_GPIO)) gpio <= wdata;
      // A new error in the same cycle as a clear keeps the flag set.
      err <= (err && !clr_err) || err_set;
      ovf <= (ovf && !clr_ovf) || ovf_set;
    end
  end

  always_comb begin
    status             = '0;
    status[STATUS_ERR] = err;
    status[STATUS_OVF] = ovf;
  end

`ifdef MISAO_MEM_TIMER_EN
  logic [15:0] timer;
  logic [7:0]  shadow;

  // Reading the low byte freezes the high byte so a 16-bit read is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer  <= '0;
      shadow <= '0;
    end else begin
      if (run) timer <= timer + 16'd1;
      if (rd && (offset == IO_TMR_LO)) shadow <= timer[15:8];
    end
  end

  assign tmr_lo = DATA_W'(timer[7:0]);
  assign tmr_hi = DATA_W'(shadow);
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = run ^ rd;
  assign tmr_lo = '0;
  assign tmr_hi = '0;
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      IO_GPIO:   rdata = gpio;
      IO_TMR_LO: rdata = tmr_lo;
      IO_TMR_HI: rdata = tmr_hi;
      IO_STATUS: rdata = status;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/misao_mem_responder.sv
// Memory responder for the misao core: boot-loads RAM, then serves core reads and
// writes to RAM and a 4-byte I/O window. Optional timer: define MISAO_MEM_TIMER_EN.
module misao_mem_responder
  import misao_mem_pkg::*;
#(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 8,
  parameter int                RAM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] IO_BASE   = 15'h7F00
) (
  input  logic                         clk,
  input  logic                         rst,
  misao_mem_responder_if.slave         bus,
  output state_t                       state,
  output logic [$clog2(RAM_DEPTH)-1:0] load_ptr
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  state_t            state_next;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic              run;
  logic              load_accept;
  logic              load_done;
  logic              ovf_set;
  logic              rd_active;
  logic              wr_active;
  logic              in_ram;
  logic              in_io;
  logic              unmapped;
  logic              err_set;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] rdata;
  logic              unused_rw;

  // The enables alone decide the access; the direction flag is informational.
  assign unused_rw = bus.mem_rw;

  assign run          = (state == RUN);
  assign bus.ld_ready = (state == LOAD) && rst;
  assign bus.core_rst = !run;

  assign load_accept = bus.ld_valid && bus.ld_ready;
  assign load_done   = load_accept && (bus.ld_last || (&load_ptr));
  assign ovf_set     = load_accept && !bus.ld_last && (&load_ptr);

  assign ram_idx   = bus.mem_addr[RAM_AW-1:0];
  assign in_ram    = (bus.mem_addr[ADDR_W-1:RAM_AW] == '0);
  assign in_io     = (bus.mem_addr[ADDR_W-1:2] == IO_BASE[ADDR_W-1:2]);
  assign unmapped  = !in_ram && !in_io;
  assign rd_active = run && bus.mem_enable_read;
  assign wr_active = run && bus.mem_enable_write;
  assign err_set   = ((rd_active || wr_active) && unmapped) || (rd_active && wr_active);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_done) state_next = RELEASE;
      RELEASE: state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             load_ptr <= '0;
    else if (load_accept) load_ptr <= load_ptr + 1'b1;
  end

  // RAM has no reset so a reset mid-boot keeps the bytes already streamed in.
  always_ff @(posedge clk) begin
    if (load_accept)                ram[load_ptr] <= bus.ld_data;
    else if (wr_active && in_ram)   ram[ram_idx]  <= bus.mem_data_out;
  end

  misao_io_regs #(.DATA_W(DATA_W)) u_io_regs (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .rd      (rd_active && in_io),
    .wr      (wr_active && in_io),
    .offset  (bus.mem_addr[1:0]),
    .wdata   (bus.mem_data_out),
    .err_set (err_set),
    .ovf_set (ovf_set),
    .rdata   (io_rdata),
    .gpio    (bus.gpio_out),
    .err     (bus.err_access)
  );

  always_comb begin
    rdata = '0;
    if (rd_active) begin
      if (in_ram)     rdata = ram[ram_idx];
      else if (in_io) rdata = io_rdata;
    end
  end

  assign bus.mem_data_in = rdata;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Self-checking bench for misao_mem_responder: directed boot/bus scenarios plus a
// randomized bus phase checked against a behavioural memory-map model.
module tb_misao_mem_responder;
  import misao_mem_pkg::*;

  localparam int          ADDR_W    = 15;
  localparam int          DATA_W    = 8;
  localparam int          RAM_DEPTH = 256;
  localparam logic [14:0] IO_BASE   = 15'h7F00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  state_t      state;
  logic [7:0]  load_ptr;

  misao_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  misao_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH), .IO_BASE(IO_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state    (state),
    .load_ptr (load_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // scoreboard / model state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  m_ram   [RAM_DEPTH];
  bit          m_known [RAM_DEPTH];
  logic [7:0]  m_gpio   = '0;
  logic [7:0]  m_shadow = '0;
  bit          m_err    = 0;
  bit          m_ovf    = 0;
  bit          m_run    = 0;
  int unsigned run_start = 0;
  logic [7:0]  boot_buf [RAM_DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Timer counts posedges spent in RUN; RUN begins one edge after the release edge.
  function automatic logic [15:0] m_timer();
    return 16'(cycle - run_start);
  endfunction

  function automatic bit is_io(input logic [14:0] a);
    return (a >= IO_BASE) && (a <= IO_BASE + 15'd3);
  endfunction

  // Returns {comparable, value} for a read of address a at timer value t.
  function automatic logic [8:0] model_read(input logic [14:0] a, input logic [15:0] t);
    if (a < 15'(RAM_DEPTH)) return {m_known[a[7:0]], m_ram[a[7:0]]};
    if (a == IO_BASE)         return {1'b1, m_gpio};
`ifdef MISAO_MEM_TIMER_EN
    if (a == IO_BASE + 15'd1) return {1'b1, t[7:0]};
    if (a == IO_BASE + 15'd2) return {1'b1, m_shadow};
`else
    if (a == IO_BASE + 15'd1) return {1'b1, 8'h00 | 8'(t & 16'h0)};
    if (a == IO_BASE + 15'd2) return 9'h100;
`endif
    if (a == IO_BASE + 15'd3) return {1'b1, 6'b0, m_ovf, m_err};
    return 9'h100;
  endfunction

  task automatic model_commit(input logic rd, input logic wr, input logic [14:0] a,
                              input logic [7:0] d, input logic [15:0] t);
    bit unm;
    unm = !(a < 15'(RAM_DEPTH)) && !is_io(a);
    if (rd && a == IO_BASE + 15'd1) m_shadow = t[15:8];
    if (wr) begin
      if (a < 15'(RAM_DEPTH)) begin
        m_ram[a[7:0]]   = d;
        m_known[a[7:0]] = 1;
      end else if (a == IO_BASE) begin
        m_gpio = d;
      end else if (a == IO_BASE + 15'd3) begin
        if (d[0]) m_err = 0;
        if (d[1]) m_ovf = 0;
      end
    end
    if (((rd || wr) && unm) || (rd && wr)) m_err = 1;
  endtask

  // driver: one bus cycle, read data checked mid-cycle, side effects after the edge
  task automatic bus_op(input logic rd, input logic wr, input logic [14:0] a, input logic [7:0] d);
    logic [8:0]  r;
    logic [15:0] t;
    @(negedge clk);
    bus.mem_enable_read  = rd;
    bus.mem_enable_write = wr;
    bus.mem_addr         = a;
    bus.mem_data_out     = d;
    bus.mem_rw           = 1'($urandom_range(0, 1));
    t = m_timer();
    r = model_read(a, t);
    if (!(m_run && rd)) r = 9'h100;
    #1;
    if (r[8]) begin
      exp_q.push_back(r[7:0]);
      check("mem_data_in", 32'(bus.mem_data_in), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (m_run) model_commit(rd, wr, a, d, t);
    #1;
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
    check("err_access", 32'(bus.err_access), 32'(m_err));
    check("gpio_out", 32'(bus.gpio_out), 32'(m_gpio));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    #1;
    check("rst_core_rst", 32'(bus.core_rst), 32'd1);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_gpio", 32'(bus.gpio_out), 32'd0);
    check("rst_err", 32'(bus.err_access), 32'd0);
    check("rst_state", 32'(state), 32'(LOAD));
    check("rst_ptr", 32'(load_ptr), 32'd0);
    m_err = 0; m_ovf = 0; m_gpio = '0; m_shadow = '0; m_run = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Streams boot_buf[0..n-1] with random idle gaps; ld_last on the final byte if last.
  task automatic load_bytes(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        bus.ld_valid = 1'b0;
      end
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data  = boot_buf[i];
      bus.ld_last  = last && (i == n - 1);
      #1;
      check("ld_ready", 32'(bus.ld_ready), 32'd1);
      @(posedge clk);
      m_ram[i]   = boot_buf[i];
      m_known[i] = 1;
      if (i == RAM_DEPTH - 1 && !(last && i == n - 1)) m_ovf = 1;
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic finish_boot();
    run_start = cycle + 1;
    check("release_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("release_core_rst", 32'(bus.core_rst), 32'd1);
    check("release_state", 32'(state), 32'(RELEASE));
    @(negedge clk);
    check("run_core_rst", 32'(bus.core_rst), 32'd0);
    check("run_state", 32'(state), 32'(RUN));
    m_run = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    bus.mem_enable_read  = 1'b0;
    bus.mem_enable_write = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_rw           = 1'b0;
    bus.mem_data_out     = '0;
    bus.ld_valid         = 1'b0;
    bus.ld_data          = '0;
    bus.ld_last          = 1'b0;
    repeat (2) @(negedge clk);
    apply_reset();

    // reset in the middle of a boot keeps streamed bytes, restarts the pointer
    boot_buf[0] = 8'($urandom); boot_buf[1] = 8'($urandom);
    load_bytes(2, 0);
    check("midload_ptr", 32'(load_ptr), 32'd2);
    check("midload_core_rst", 32'(bus.core_rst), 32'd1);
    apply_reset();
    boot_buf[0] = 8'($urandom);
    load_bytes(1, 1);
    finish_boot();
    bus_op(1, 0, 15'h0000, 8'h00);
    bus_op(1, 0, 15'h0001, 8'h00);

    // strobes before RUN are ignored, then the reference 3-byte boot
    apply_reset();
    bus_op(1, 1, 15'h1000, 8'h55);
    boot_buf[0] = 8'h18; boot_buf[1] = 8'h4C; boot_buf[2] = 8'h54;
    load_bytes(3, 1);
    finish_boot();
    for (int i = 0; i < 3; i++) bus_op(1, 0, 15'(i), 8'h00);
    bus_op(1, 0, IO_BASE + 15'd3, 8'h00);

`ifdef MISAO_MEM_TIMER_EN
    begin
      int guard;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (m_timer() != 16'h01FD && guard < 2000);
      check("timer_reach", 32'(guard < 2000), 32'd1);
    end
    bus_op(1, 0, IO_BASE + 15'd1, 8'h00);
    repeat (3) @(negedge clk);
    bus_op(1, 0, IO_BASE + 15'd2, 8'h00);
`else
    bus_op(1, 0, IO_BASE + 15'd1, 8'h00);
    bus_op(1, 0, IO_BASE + 15'd2, 8'h00);
`endif

    // directed RUN accesses and error handling
    bus_op(0, 1, 15'h0010, 8'hA5);
    bus_op(1, 0, 15'h0010, 8'h00);
    bus_op(0, 0, 15'h0010, 8'h00);
    bus_op(0, 1, IO_BASE, 8'h3C);
    bus_op(1, 0, IO_BASE, 8'h00);
    bus_op(1, 0, 15'h1000, 8'h00);
    bus_op(0, 1, IO_BASE + 15'd3, 8'h01);
    bus_op(1, 1, 15'h0010, 8'h77);
    bus_op(1, 0, 15'h0010, 8'h00);
    bus_op(1, 1, IO_BASE + 15'd3, 8'h01);
    bus_op(0, 1, IO_BASE + 15'd3, 8'h03);

    // randomized bus traffic
    for (int k = 0; k < 300; k++) begin
      int          cls;
      int          op;
      logic [14:0] a;
      cls = $urandom_range(0, 9);
      op  = $urandom_range(0, 9);
      if (cls < 5)      a = 15'($urandom_range(0, 31));
      else if (cls < 8) a = IO_BASE + 15'($urandom_range(0, 3));
      else if (cls < 9) a = 15'($urandom_range(RAM_DEPTH, 32'h7EFF));
      else              a = 15'($urandom_range(32'h7F04, 32'h7FFF));
      bus_op(op < 5 || op == 9, op >= 5, a, 8'($urandom));
    end

    // overflow boot: 256 bytes with no ld_last
    apply_reset();
    for (int i = 0; i < RAM_DEPTH; i++) boot_buf[i] = 8'($urandom);
    load_bytes(RAM_DEPTH, 0);
    finish_boot();
    bus_op(1, 0, IO_BASE + 15'd3, 8'h00);
    for (int i = 0; i < 16; i++) bus_op(1, 0, 15'($urandom_range(0, RAM_DEPTH - 1)), 8'h00);
    bus_op(1, 0, 15'(RAM_DEPTH - 1), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
